vm_txn_ctrl: RTL and testbench

Transaction controller for the vending machine. It sequences the coin, selection, dispense and change datapath, and owns the credit register, per-item stock counters, greedy change issue and error reporting. It sits between the input conditioning logic (coins, goods select, buy/cancel) and the dispense/change actuators and display logic.

---
 rtl/vm_txn_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_vm_txn_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_txn_ctrl.sv
// Vending machine transaction controller: credit, per-item stock, vend handshake and greedy change.
// Optional macro TIMEOUT_EN: auto-refund after TIMEOUT idle cycles in CREDIT.
module vm_txn_ctrl #(
  parameter int CREDIT_W   = 7,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5,
  parameter int PRICE0     = 2,
  parameter int PRICE1     = 3,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 7,
  parameter int TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic [3:0]          goods,
  input  logic                buy,
  input  logic                cancel,
  input  logic                restock,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  input  logic                dispense_ack,
  output logic                change_valid,
  output logic [1:0]          change_val,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          stock_empty,
  output logic                coin_reject,
  output logic                err_funds,
  output logic                err_nostock,
  output logic                err_sel,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [STOCK_W-1:0]  stock_q [4];
  logic                dispense_valid_q;
  logic [1:0]          dispense_item_q;
  logic                change_valid_q;
  logic [1:0]          change_val_q;
  logic                coin_reject_q;
  logic                err_funds_q;
  logic                err_nostock_q;
  logic                err_sel_q;

  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] code);
    case (code)
      2'd0:    return CREDIT_W'(1);
      2'd1:    return CREDIT_W'(2);
      2'd2:    return CREDIT_W'(5);
      default: return CREDIT_W'(10);
    endcase
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] greedy_code(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(10)) return 2'd3;
    if (c >= CREDIT_W'(5))  return 2'd2;
    if (c >= CREDIT_W'(2))  return 2'd1;
    return 2'd0;
  endfunction

  logic                goods_onehot;
  logic [1:0]          goods_idx;
  logic [CREDIT_W-1:0] price_sel;
  logic                sel_empty;
  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] credit_left;
  logic                timeout_fire;

  assign goods_onehot = $onehot(goods);

  always_comb begin
    goods_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (goods[i]) goods_idx = 2'(i);
    end
  end

  always_comb begin
    case (goods_idx)
      2'd0:    price_sel = CREDIT_W'(PRICE0);
      2'd1:    price_sel = CREDIT_W'(PRICE1);
      2'd2:    price_sel = CREDIT_W'(PRICE2);
      default: price_sel = CREDIT_W'(PRICE3);
    endcase
  end

  assign sel_empty   = (stock_q[goods_idx] == '0);
  assign coin_amt    = coin_units(coin_val);
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_amt};
  assign credit_left = credit_q - coin_units(change_val_q);

`ifdef TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt_q;

  assign timeout_fire = (state_q == S_CREDIT) && !coin_valid && !buy && !cancel &&
                        (idle_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else if (state_q != S_CREDIT || coin_valid || buy || cancel || timeout_fire) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + TO_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout_fire   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      credit_q         <= '0;
      dispense_valid_q <= 1'b0;
      dispense_item_q  <= 2'd0;
      change_valid_q   <= 1'b0;
      change_val_q     <= 2'd0;
      coin_reject_q    <= 1'b0;
      err_funds_q      <= 1'b0;
      err_nostock_q    <= 1'b0;
      err_sel_q        <= 1'b0;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      coin_reject_q <= 1'b0;
      err_funds_q   <= 1'b0;
      err_nostock_q <= 1'b0;
      err_sel_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (restock) begin
            for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
          end
          if (buy) begin
            if (!goods_onehot)             err_sel_q     <= 1'b1;
            else if (sel_empty)            err_nostock_q <= 1'b1;
            else if (credit_q < price_sel) err_funds_q   <= 1'b1;
          end
          if (coin_valid) begin
            credit_q <= coin_amt;
            state_q  <= S_CREDIT;
          end
        end

        S_CREDIT: begin
          if (cancel || timeout_fire) begin
            coin_reject_q <= coin_valid;
            if (credit_q != '0) begin
              state_q        <= S_CHANGE;
              change_valid_q <= 1'b1;
              change_val_q   <= greedy_code(credit_q);
            end else begin
              state_q <= S_IDLE;
            end
          end else if (buy) begin
            coin_reject_q <= coin_valid;
            if (!goods_onehot) begin
              err_sel_q <= 1'b1;
            end else if (sel_empty) begin
              err_nostock_q <= 1'b1;
            end else if (credit_q < price_sel) begin
              err_funds_q <= 1'b1;
            end else begin
              credit_q           <= credit_q - price_sel;
              stock_q[goods_idx] <= stock_q[goods_idx] - STOCK_W'(1);
              dispense_item_q    <= goods_idx;
              dispense_valid_q   <= 1'b1;
              state_q            <= S_VEND;
            end
          end else if (coin_valid) begin
            if (coin_sum[CREDIT_W]) coin_reject_q <= 1'b1;
            else                    credit_q      <= coin_sum[CREDIT_W-1:0];
          end
        end

        S_VEND: begin
          coin_reject_q <= coin_valid;
          if (dispense_ack && dispense_valid_q) begin
            dispense_valid_q <= 1'b0;
            if (credit_q != '0) begin
              state_q        <= S_CHANGE;
              change_valid_q <= 1'b1;
              change_val_q   <= greedy_code(credit_q);
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_CHANGE: begin
          coin_reject_q <= coin_valid;
          if (change_ack && change_valid_q) begin
            credit_q <= credit_left;
            if (credit_left == '0) begin
              change_valid_q <= 1'b0;
              state_q        <= S_IDLE;
            end else begin
              change_val_q <= greedy_code(credit_left);
            end
          end
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_empty
      assign stock_empty[gi] = (stock_q[gi] == '0);
    end
  endgenerate

  assign dispense_valid = dispense_valid_q;
  assign dispense_item  = dispense_item_q;
  assign change_valid   = change_valid_q;
  assign change_val     = change_val_q;
  assign credit         = credit_q;
  assign coin_reject    = coin_reject_q;
  assign err_funds      = err_funds_q;
  assign err_nostock    = err_nostock_q;
  assign err_sel        = err_sel_q;
  assign state          = state_q;

endmodule

// File: tb/tb_vm_txn_ctrl.sv
// Self-checking bench for vm_txn_ctrl: directed scenarios plus random sessions against a credit/stock model.
module tb_vm_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid, buy, cancel, restock, dispense_ack, change_ack;
  logic [1:0] coin_val;
  logic [3:0] goods;
  logic       dispense_valid, change_valid;
  logic [1:0] dispense_item, change_val, state;
  logic [6:0] credit;
  logic [3:0] stock_empty;
  logic       coin_reject, err_funds, err_nostock, err_sel;

  int total = 0;
  int bad   = 0;

  // Model: what the machine owes the customer and what is left on the shelves.
  int m_credit;
  int m_stock [4];
  int price   [4] = '{2, 3, 5, 7};
  int units   [4] = '{1, 2, 5, 10};

  always #5 clk = ~clk;

  vm_txn_ctrl #(
    .CREDIT_W(7), .STOCK_W(4), .STOCK_INIT(5),
    .PRICE0(2), .PRICE1(3), .PRICE2(5), .PRICE3(7),
    .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_val(coin_val), .goods(goods),
    .buy(buy), .cancel(cancel), .restock(restock),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item), .dispense_ack(dispense_ack),
    .change_valid(change_valid), .change_val(change_val), .change_ack(change_ack),
    .credit(credit), .stock_empty(stock_empty),
    .coin_reject(coin_reject), .err_funds(err_funds), .err_nostock(err_nostock), .err_sel(err_sel),
    .state(state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (m_stock[i] == 0);
    return e;
  endfunction

  function automatic int greedy(input int owed);
    for (int c = 3; c >= 0; c--) if (units[c] <= owed) return c;
    return 0;
  endfunction

  function automatic int quiet_state();
    return (m_credit > 0) ? 1 : 0;
  endfunction

  task automatic check_pulses(input string tag, input bit rej, input bit es, input bit en, input bit ef);
    check({tag, "_rej"}, coin_reject, rej);
    check({tag, "_sel"}, err_sel, es);
    check({tag, "_nostock"}, err_nostock, en);
    check({tag, "_funds"}, err_funds, ef);
  endtask

  task automatic do_coin(input int code);
    bit rej;
    coin_valid = 1'b1;
    coin_val   = 2'(code);
    tick();
    coin_valid = 1'b0;
    rej = (m_credit + units[code] > 127);
    if (!rej) m_credit += units[code];
    check_pulses("coin", rej, 1'b0, 1'b0, 1'b0);
    check("coin_credit", credit, m_credit);
    check("coin_state", state, quiet_state());
    $display("txn coin value=%0d reject=%0d credit=%0d", units[code], rej, m_credit);
  endtask

  // Take every change coin until the model credit is paid out.
  task automatic collect_change(input int first_delay);
    int owed;
    int code;
    int d;
    int n;
    owed = m_credit;
    n = 0;
    while (owed > 0) begin
      code = greedy(owed);
      check("chg_valid", change_valid, 1);
      check("chg_val", change_val, code);
      check("chg_credit", credit, owed);
      check("chg_state", state, 3);
      d = (n == 0 && first_delay >= 0) ? first_delay : int'($urandom_range(0, 2));
      for (int i = 0; i < d; i++) begin
        if (n == 0 && i == 0) begin
          coin_valid = 1'b1;
          coin_val   = 2'($urandom);
        end
        tick();
        coin_valid = 1'b0;
        check("chg_hold_valid", change_valid, 1);
        check("chg_hold_val", change_val, code);
        check("chg_hold_rej", coin_reject, (n == 0 && i == 0));
      end
      change_ack = 1'b1;
      tick();
      change_ack = 1'b0;
      owed -= units[code];
      n++;
      $display("txn change coin=%0d owed=%0d", units[code], owed);
    end
    m_credit = 0;
    check("chg_end_valid", change_valid, 0);
    check("chg_end_state", state, 0);
    check("chg_end_credit", credit, 0);
  endtask

  task automatic do_buy(input logic [3:0] g, input bit with_coin);
    int  idx;
    int  d;
    bit  es, en, ef, ok;
    es = 0; en = 0; ef = 0; ok = 0; idx = 0;
    if ($countones(g) != 1) es = 1;
    else begin
      for (int i = 0; i < 4; i++) if (g[i]) idx = i;
      if (m_stock[idx] == 0) en = 1;
      else if (m_credit < price[idx]) ef = 1;
      else ok = 1;
    end
    buy   = 1'b1;
    goods = g;
    if (with_coin) begin
      coin_valid = 1'b1;
      coin_val   = 2'($urandom);
    end
    tick();
    buy = 1'b0;
    coin_valid = 1'b0;
    check_pulses("buy", with_coin, es, en, ef);
    $display("txn buy goods=%b sel=%0d nostock=%0d funds=%0d ok=%0d", g, es, en, ef, ok);
    if (ok) begin
      m_credit -= price[idx];
      m_stock[idx]--;
      check("vend_valid", dispense_valid, 1);
      check("vend_item", dispense_item, idx);
      check("vend_credit", credit, m_credit);
      check("vend_state", state, 2);
      check("vend_empty", stock_empty, exp_empty());
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        if (i == 0) begin
          coin_valid = 1'b1;
          coin_val   = 2'($urandom);
        end
        tick();
        coin_valid = 1'b0;
        check("vend_hold_valid", dispense_valid, 1);
        check("vend_hold_item", dispense_item, idx);
        check("vend_hold_rej", coin_reject, (i == 0));
      end
      dispense_ack = 1'b1;
      tick();
      dispense_ack = 1'b0;
      check("vend_ack_valid", dispense_valid, 0);
      check("vend_ack_state", state, (m_credit > 0) ? 3 : 0);
      if (m_credit > 0) collect_change(-1);
    end else begin
      check("buyerr_state", state, quiet_state());
      check("buyerr_credit", credit, m_credit);
      check("buyerr_dvalid", dispense_valid, 0);
    end
  endtask

  task automatic do_cancel(input bit with_coin, input int first_delay);
    cancel = 1'b1;
    if (with_coin) begin
      coin_valid = 1'b1;
      coin_val   = 2'($urandom);
    end
    tick();
    cancel = 1'b0;
    coin_valid = 1'b0;
    $display("txn cancel credit=%0d", m_credit);
    if (m_credit > 0) begin
      check("cancel_rej", coin_reject, with_coin);
      check("cancel_state", state, 3);
      collect_change(first_delay);
    end else begin
      check("cancel_idle_state", state, 0);
      check("cancel_idle_cvalid", change_valid, 0);
    end
  endtask

  task automatic do_restock();
    restock = 1'b1;
    tick();
    restock = 1'b0;
    if (m_credit == 0) for (int i = 0; i < 4; i++) m_stock[i] = 5;
    check("restock_empty", stock_empty, exp_empty());
    check("restock_state", state, quiet_state());
    $display("txn restock honoured=%0d", (m_credit == 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_empty"}, stock_empty, 0);
    check({tag, "_dvalid"}, dispense_valid, 0);
    check({tag, "_ditem"}, dispense_item, 0);
    check({tag, "_cvalid"}, change_valid, 0);
    check({tag, "_cval"}, change_val, 0);
    check_pulses(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] g;
    int op;
    rst = 1'b1;
    coin_valid = 1'b0; coin_val = 2'd0; goods = 4'd0; buy = 1'b0; cancel = 1'b0;
    restock = 1'b0; dispense_ack = 1'b0; change_ack = 1'b0;
    m_credit = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 5;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 5 + 2, buy item 1, change 2 + 2
    do_coin(2);
    do_coin(1);
    do_buy(4'b0010, 1'b0);

    // Insufficient funds, then refund
    do_coin(1);
    do_buy(4'b1000, 1'b0);
    do_cancel(1'b0, -1);

    // Exhaust item 0, then restock
    for (int k = 0; k < 5; k++) begin
      do_coin(1);
      do_buy(4'b0001, 1'b0);
    end
    check("item0_empty", stock_empty[0], 1);
    do_coin(1);
    do_buy(4'b0001, 1'b0);
    do_cancel(1'b0, -1);
    do_restock();

    // Bad selection, then a buy racing a coin
    do_coin(1);
    do_coin(2);
    do_buy(4'b0110, 1'b0);
    do_buy(4'b0010, 1'b1);

    // Acks with no request pending are ignored
    dispense_ack = 1'b1;
    change_ack   = 1'b1;
    tick();
    dispense_ack = 1'b0;
    change_ack   = 1'b0;
    check("stray_ack_state", state, 0);
    check("stray_ack_dvalid", dispense_valid, 0);
    check("stray_ack_cvalid", change_valid, 0);

    // Credit near the top, overflowing coin, long change run
    for (int k = 0; k < 12; k++) do_coin(3);
    do_coin(3);
    do_cancel(1'b0, 3);

`ifdef TIMEOUT_EN
    do_coin(0);
    repeat (19) tick();
    check("to_before_state", state, 1);
    tick();
    check("to_state", state, 3);
    check("to_cval", change_val, 0);
    collect_change(0);
`else
    do_coin(0);
    repeat (30) tick();
    check("persist_state", state, 1);
    check("persist_credit", credit, 1);
    do_cancel(1'b0, -1);
`endif

    // Random sessions
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 7);
      if (op <= 3) begin
        do_coin($urandom_range(0, 3));
      end else if (op <= 5) begin
        if ($urandom_range(0, 3) != 0) g = 4'b0001 << $urandom_range(0, 3);
        else g = 4'($urandom);
        do_buy(g, (m_credit > 0) && ($urandom_range(0, 3) == 0));
      end else if (op == 6) begin
        do_cancel((m_credit > 0) && ($urandom_range(0, 3) == 0), -1);
      end else begin
        do_restock();
      end
    end
    if (m_credit > 0) do_cancel(1'b0, -1);

    // Empty item 3 then reset in the middle of a refund
    do_restock();
    for (int k = 0; k < 5; k++) begin
      do_coin(2);
      do_coin(1);
      do_buy(4'b1000, 1'b0);
    end
    check("item3_empty", stock_empty[3], 1);
    do_coin(3);
    do_coin(3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("mid_change_state", state, 3);
    rst = 1'b1;
    #1;
    m_credit = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 5;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
